// File: rtl/endmodule_label_pipe.sv
// endmodule_label_pipe: WIDTH-bit, DEPTH-stage registered delay line with
// per-stage valid bits, a stall enable, a synchronous flush and an occupancy
// counter that always equals the number of valid stages.
//
// Optional feature macro: ENDMODULE_LABEL_PIPE_PARITY_EN
//   When defined, each stage also carries an even-parity bit that is computed
//   from d at stage 0. A sticky perr output flags a parity mismatch seen on a
//   valid last stage. When undefined, there is no parity storage and no perr
//   port.
module endmodule_label_pipe #(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                         c,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             d,
    input  logic                         d_valid,
    output logic [WIDTH-1:0]             q,
    output logic                         q_valid,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef ENDMODULE_LABEL_PIPE_PARITY_EN
    ,
    output logic                         perr
`endif
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [OCC_W-1:0] r_occ;

    logic [OCC_W-1:0] w_occIn;
    logic [OCC_W-1:0] w_occOut;

    assign w_occIn  = OCC_W'(d_valid);
    assign w_occOut = OCC_W'(r_valid[DEPTH-1]);

    // Data, valid and occupancy advance together: rst beats flush beats en.
    // Data shifts regardless of valid so the invalid stages stay deterministic.
    always_ff @(posedge c) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RESET_VALUE;
            end
            r_valid <= '0;
            r_occ   <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_occ   <= '0;
        end else if (en) begin
            r_data[0]  <= d;
            r_valid[0] <= d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_data[i]  <= r_data[i-1];
                r_valid[i] <= r_valid[i-1];
            end
            r_occ <= r_occ + w_occIn - w_occOut;
        end
    end

    assign q         = r_data[DEPTH-1];
    assign q_valid   = r_valid[DEPTH-1];
    assign occupancy = r_occ;

`ifdef ENDMODULE_LABEL_PIPE_PARITY_EN
    logic [DEPTH-1:0] r_par;
    logic             r_perr;
    logic             w_lastMismatch;

    assign w_lastMismatch = r_valid[DEPTH-1] & ((^r_data[DEPTH-1]) ^ r_par[DEPTH-1]);

    // Parity bits follow the data exactly; flush leaves them alone like the data.
    always_ff @(posedge c) begin
        if (rst) begin
            r_par <= {DEPTH{^RESET_VALUE}};
        end else if (!flush && en) begin
            r_par[0] <= ^d;
            for (int i = 1; i < DEPTH; i++) begin
                r_par[i] <= r_par[i-1];
            end
        end
    end

    // Sticky error flag: only rst clears it, so a flush cannot hide a fault.
    always_ff @(posedge c) begin
        if (rst) begin
            r_perr <= 1'b0;
        end else if (w_lastMismatch) begin
            r_perr <= 1'b1;
        end
    end

    assign perr = r_perr;
`endif

endmodule : endmodule_label_pipe

// File: tb/tb_endmodule_label_pipe.sv
// Scoreboard bench for endmodule_label_pipe (WIDTH=8, DEPTH=4).
// Words entering the pipe are queued with the enabled-edge index that
// captured them; each cycle the head of the queue predicts q/q_valid and the
// queue length predicts occupancy.
module tb_endmodule_label_pipe;

    localparam int               WIDTH = 8;
    localparam int               DEPTH = 4;
    localparam logic [WIDTH-1:0] RST_V = 8'h00;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               tag;
    } entry_t;

    logic             c = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic             d_valid = 1'b0;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [2:0]       occupancy;
`ifdef ENDMODULE_LABEL_PIPE_PARITY_EN
    logic             perr;
`endif

    entry_t sb[$];
    int     enCount = 0;
    int     vectorCount = 0;
    int     missCount = 0;

    endmodule_label_pipe #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .RESET_VALUE(RST_V)
    ) dut (
        .c(c),
        .rst(rst),
        .en(en),
        .flush(flush),
        .d(d),
        .d_valid(d_valid),
        .q(q),
        .q_valid(q_valid),
        .occupancy(occupancy)
`ifdef ENDMODULE_LABEL_PIPE_PARITY_EN
        ,
        .perr(perr)
`endif
    );

    // Free-running clock, 10 time units per period.
    always #5 c = ~c;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the scoreboard
    // and compare the DUT outputs against its prediction.
    task automatic applyStimulus(input logic rstV, input logic flushV, input logic enV,
                                 input logic [WIDTH-1:0] dV, input logic dvV);
        bit expValid;
        @(negedge c);
        rst     = rstV;
        flush   = flushV;
        en      = enV;
        d       = dV;
        d_valid = dvV;
        @(posedge c);
        #1;
        if (rstV) begin
            sb.delete();
        end else if (flushV) begin
            sb.delete();
        end else if (enV) begin
            if (sb.size() > 0 && sb[0].tag + DEPTH - 1 == enCount) begin
                void'(sb.pop_front());
            end
            enCount++;
            if (dvV) begin
                sb.push_back('{data: dV, tag: enCount});
            end
        end
        expValid = (sb.size() > 0) && (sb[0].tag + DEPTH - 1 == enCount);
        checkOutput("q_valid", 32'(q_valid), 32'(expValid));
        if (expValid) begin
            checkOutput("q_data", 32'(q), 32'(sb[0].data));
        end
        checkOutput("occupancy", 32'(occupancy), 32'(sb.size()));
        if (rstV) begin
            checkOutput("q_after_rst", 32'(q), 32'(RST_V));
        end
`ifdef ENDMODULE_LABEL_PIPE_PARITY_EN
        checkOutput("perr", 32'(perr), 32'd0);
`endif
    endtask

    initial begin
        // Reset held two cycles while the inputs try to load 8'hFF.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);

        // Latency: one valid word followed by bubbles.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        end

        // Stall mid-stream: 01..04, en low three cycles, then drain.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h01, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h02, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'hEE, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h03, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h04, 1'b1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        end

        // Full pipe with simultaneous entry and exit.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h30 + i), 1'b1);
        end
        checkOutput("occ_saturated", 32'(occupancy), 32'd4);

        // Flush with three words in flight and a valid word arriving.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h51, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h52, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h53, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h5F, 1'b1);
        checkOutput("flush_occ", 32'(occupancy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        end

        // rst and flush together after loading a few words.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h61, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h62, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h63, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h64, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h6F, 1'b1);

        // Random traffic with random stalls and rare flushes.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b0, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
                          8'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule : tb_endmodule_label_pipe
